fir_axil_cfg_master: RTL and testbench
======================================

// Module: fir_axil_cfg_master
// PURPOSE
//  AXI4-Lite initiator that configures and polls the FIR block's AXI-Lite register slave.
//  It turns a simple one-at-a-time command port into AXI-Lite transactions:
//   - write: AW and W channels; the FIR slave has no B channel.
//   - read: AR and R channels.
//  The firmware/testbench sequencer uses it for tap loading, data-length programming, ap_start and ap_done polling.
//  It returns a response with read data and an error flag on timeout or a misaligned address.
// PARAMETERS
//  pADDR_WIDTH     12    AXI-Lite address width
//  pDATA_WIDTH     32    AXI-Lite data width
//  TIMEOUT_CYCLES  256   max cycles from issue to completion; 0 disables the timeout
// PORTS
//  axis_clk    in   1   clock; all logic rising-edge
//  axis_rst    in   1   synchronous reset, active-high
//  cmd_valid   in   1   command request
//  cmd_ready   out  1   command accepted when cmd_valid && cmd_ready
//  cmd_write   in   1   1=write, 0=read
//  cmd_addr    in   pADDR_WIDTH  byte address
//  cmd_wdata   in   pDATA_WIDTH  write data
//  rsp_valid   out  1   response available
//  rsp_ready   in   1   response consumed when rsp_valid && rsp_ready
//  rsp_rdata   out  pDATA_WIDTH  read data (0 for writes and errors)
//  rsp_err     out  1   1=timeout or misaligned address
//  busy        out  1   state != IDLE
//  awvalid/awaddr out 1/pADDR_WIDTH,  awready in 1
//  wvalid/wdata   out 1/pDATA_WIDTH,  wready  in 1
//  arvalid/araddr out 1/pADDR_WIDTH,  arready in 1
//  rvalid in 1, rdata in pDATA_WIDTH, rready out 1
// BEHAVIOUR
//  Reset: all outputs 0 (cmd_ready=1 from the first cycle after reset), state IDLE, timeout counter 0.
//  FSM states: IDLE, WR (AW+W outstanding), RD_A, RD_D, RESP.
//  IDLE:
//   - cmd_ready=1; on accept, latch addr, wdata and write.
//   - cmd_addr[1:0]!=0: go to RESP with rsp_err=1; no bus activity.
//   - Otherwise go to WR or RD_A.
//  WR:
//   - awvalid and wvalid rise in the cycle after accept; awaddr and wdata are held stable.
//   - Each valid drops on the edge after its own ready is sampled high. AW and W may complete in the same cycle or in either order.
//   - When both are done, go to RESP with rsp_err=0 and rsp_rdata=0.
//  RD_A:
//   - arvalid held until arready is sampled high, then go to RD_D.
//  RD_D:
//   - rready=1 for the whole state; the slave's rvalid depends on rready, so rready must not wait for rvalid.
//   - On rvalid, capture rdata into rsp_rdata and go to RESP.
//  RESP:
//   - rsp_valid=1, with rsp_rdata and rsp_err stable, until rsp_ready; then go to IDLE.
//   - rsp_rdata and rsp_err hold their values after the handshake; they change only when the next command completes or at reset.
//  Timeout:
//   - The counter clears on accept and increments each cycle in WR, RD_A and RD_D.
//   - When it reaches TIMEOUT_CYCLES and the transfer is incomplete: drop all valids and rready on the next edge, and go to RESP with rsp_err=1 and rsp_rdata=0.
//   - Completion in the same cycle as the timeout takes precedence, with err=0.
//  Rules:
//   - Only one command is outstanding at a time; a new command is never accepted in the same cycle a response is consumed.
//   - Latency with a zero-wait slave, from accept at cycle 0:
//     - write: aw/w handshake at cycle 1, rsp_valid at cycle 2.
//     - read: ar handshake at cycle 1, r at cycle 2 at the earliest, rsp_valid at cycle 3.
//   - Reset mid-transaction: every valid, ready and rsp_valid is 0 after the reset edge; the in-flight command is dropped with no response.
// TESTING
//  1. Write 0x10=600, slave ready: awvalid and wvalid high exactly 1 cycle; rsp_valid at cycle 2, err=0.
//  2. Write 0x20=0xFFFFFFF6, wready 3 cycles after awready: awvalid drops first, wvalid is held stable until its handshake, then rsp with err=0.
//  3. Read 0x00, slave returns 0x6 two cycles after rready: rsp_rdata=0x6 and err=0; rready high throughout RD_D.
//  4. Read 0x24 with arready stuck low and TIMEOUT_CYCLES=8: arvalid drops after 8 cycles; rsp_err=1, rsp_rdata=0.
//  5. Write to addr 0x22: no aw/w activity; rsp_err=1 on the next cycle.
//  6. Assert axis_rst during RD_D, then hold rsp_ready low: all outputs 0 after the edge; no rsp_valid; the next command works.

Source files
------------

// File: rtl/fir_axil_cfg_master.sv
// AXI4-Lite initiator for the FIR register slave: one command at a time in, one response out.
// Writes drive AW+W (no B channel); reads drive AR then R. Misaligned addresses and timeouts flag rsp_err.
module fir_axil_cfg_master #(
    parameter int unsigned pADDR_WIDTH    = 12,
    parameter int unsigned pDATA_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    // command port
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [pDATA_WIDTH-1:0] cmd_wdata,
    // response port
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [pDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy,
    // AXI-Lite write
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awready,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wready,
    // AXI-Lite read
    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rready
);

    typedef enum logic [2:0] {StIdle, StWr, StRdA, StRdD, StResp} state_e;

    // Timeout fires in the last allowed busy cycle, so a valid is held exactly TIMEOUT_CYCLES cycles.
    localparam bit          ToEnable = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] ToLimit  = ToEnable ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_e                 state_q, state_d;
    logic [pADDR_WIDTH-1:0] addr_q, addr_d;
    logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   aw_pend_q, aw_pend_d;
    logic                   w_pend_q, w_pend_d;
    logic [31:0]            cnt_q, cnt_d;

    logic aw_hs, w_hs, timeout_hit;

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        cnt_d       = cnt_q;
        aw_hs       = aw_pend_q && awready;
        w_hs        = w_pend_q && wready;
        timeout_hit = ToEnable && (cnt_q >= ToLimit);

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    cnt_d   = '0;
                    if (cmd_addr[1:0] != 2'b00) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (cmd_write) begin
                        state_d   = StWr;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d = StRdA;
                    end
                end
            end
            StWr: begin
                cnt_d = cnt_q + 32'd1;
                if (aw_hs) aw_pend_d = 1'b0;
                if (w_hs)  w_pend_d  = 1'b0;
                // Completion on the timeout cycle still counts as success.
                if ((!aw_pend_q || aw_hs) && (!w_pend_q || w_hs)) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end else if (timeout_hit) begin
                    aw_pend_d = 1'b0;
                    w_pend_d  = 1'b0;
                    state_d   = StResp;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                end
            end
            StRdA: begin
                cnt_d = cnt_q + 32'd1;
                if (timeout_hit) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (arready) begin
                    state_d = StRdD;
                end
            end
            StRdD: begin
                cnt_d = cnt_q + 32'd1;
                if (rvalid) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    rdata_d = rdata;
                end else if (timeout_hit) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign awvalid   = aw_pend_q;
    assign wvalid    = w_pend_q;
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign arvalid   = (state_q == StRdA);
    // rready must not wait for rvalid: the slave only drives rvalid once it sees rready.
    assign rready    = (state_q == StRdD);

endmodule

// File: tb/tb_fir_axil_cfg_master.sv
// Bench for fir_axil_cfg_master: behavioural AXI-Lite slave with programmable delays,
// reference register model feeding an expected-response queue, and an independent response monitor.
module tb_fir_axil_cfg_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int STALL = 1000;

    logic          axis_clk = 1'b0;
    logic          axis_rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, busy;
    logic [DW-1:0] rsp_rdata;
    logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;

    fir_axil_cfg_master #(
        .pADDR_WIDTH   (AW),
        .pDATA_WIDTH   (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .axis_clk (axis_clk),  .axis_rst (axis_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),  .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),   .busy     (busy),
        .awvalid  (awvalid),   .awaddr   (awaddr),    .awready  (awready),
        .wvalid   (wvalid),    .wdata    (wdata),     .wready   (wready),
        .arvalid  (arvalid),   .araddr   (araddr),    .arready  (arready),
        .rvalid   (rvalid),    .rdata    (rdata),     .rready   (rready)
    );

    always #5 axis_clk = ~axis_clk;

    int cyc = 0;
    always @(posedge axis_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Peripheral register file and the reference copy the scoreboard reasons about.
    logic [DW-1:0] mem     [1024];
    logic [DW-1:0] ref_mem [1024];

    // Slave behaviour knobs: ready delay in cycles after valid is seen (STALL = never).
    int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    int rsp_mode = 1;  // 0 random, 1 always ready, 2 never ready

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural AXI-Lite slave: decides readies at the negedge, so handshakes land on the next posedge.
    initial begin
        bit s_aw_got, s_w_got, s_wr_done, s_ar_got;
        int s_aw_cnt, s_w_cnt, s_ar_cnt, s_r_cnt;
        logic [AW-1:0] s_wa, s_ra;
        logic [DW-1:0] s_wd;
        awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
        forever begin
            @(negedge axis_clk);
            awready = 0; wready = 0; arready = 0; rvalid = 0;
            if (axis_rst || !busy) begin
                s_aw_got = 0; s_w_got = 0; s_wr_done = 0; s_ar_got = 0;
                s_aw_cnt = 0; s_w_cnt = 0; s_ar_cnt = 0; s_r_cnt = 0;
            end else begin
                if (awvalid && !s_aw_got) begin
                    if (s_aw_cnt >= aw_dly) begin awready = 1; s_aw_got = 1; s_wa = awaddr; end
                    else s_aw_cnt++;
                end
                if (wvalid && !s_w_got) begin
                    if (s_w_cnt >= w_dly) begin wready = 1; s_w_got = 1; s_wd = wdata; end
                    else s_w_cnt++;
                end
                if (s_aw_got && s_w_got && !s_wr_done) begin
                    mem[s_wa[11:2]] = s_wd;
                    s_wr_done = 1;
                end
                if (arvalid && !s_ar_got) begin
                    if (s_ar_cnt >= ar_dly) begin arready = 1; s_ar_got = 1; s_ra = araddr; end
                    else s_ar_cnt++;
                end
                if (rready && s_ar_got) begin
                    if (s_r_cnt >= r_dly) begin rvalid = 1; rdata = mem[s_ra[11:2]]; end
                    else s_r_cnt++;
                end
            end
        end
    end

    initial begin
        rsp_ready = 0;
        forever begin
            @(posedge axis_clk);
            #2;
            rsp_ready = (rsp_mode == 0) ? 1'($urandom_range(0, 1)) : (rsp_mode == 1);
        end
    end

    // Response monitor: pops the oldest expectation whenever a response is consumed.
    initial begin
        exp_t e;
        forever begin
            @(negedge axis_clk);
            if (!axis_rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rsp_unexpected: got err=%0b rdata=0x%0h expected none", rsp_err,
                             rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    @(negedge axis_clk);
                    check("rsp_hold", 64'({rsp_err, rsp_rdata}), 64'({e.err, e.rdata}));
                end
            end
        end
    end

    // Reference: misaligned or stalled-past-timeout -> error; writes update the register file.
    function automatic exp_t model(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        bit stalled;
        stalled = wr ? (aw_dly >= STALL || w_dly >= STALL) : (ar_dly >= STALL || r_dly >= STALL);
        e.err = 1'b0;
        e.rdata = '0;
        if (a[1:0] != 2'b00 || stalled) e.err = 1'b1;
        else if (wr) ref_mem[a[11:2]] = d;
        else e.rdata = ref_mem[a[11:2]];
        return e;
    endfunction

    task automatic wait_idle();
        int g = 0;
        @(negedge axis_clk);
        while (!cmd_ready && g < 300) begin @(negedge axis_clk); g++; end
        if (!cmd_ready) check("wait_idle", 64'(cmd_ready), 64'd1);
    endtask

    // Called at a negedge; returns #1 after the accepting edge with acc = cycle number of accept.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit push, output int acc);
        int g = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && g < 300) begin @(negedge axis_clk); g++; end
        if (!cmd_ready) check("cmd_accept", 64'(cmd_ready), 64'd1);
        acc = cyc;
        if (push) exp_q.push_back(model(wr, a, d));
        @(posedge axis_clk);
        #1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    endtask

    task automatic watch(input logic [DW-1:0] wd_exp, output int aw_n, output int w_n,
                         output int ar_n, output int rr_n, output int rsp_c, output bit wd_ok);
        aw_n = 0; w_n = 0; ar_n = 0; rr_n = 0; rsp_c = -1; wd_ok = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge axis_clk);
            if (rsp_valid) begin rsp_c = cyc; break; end
            aw_n += int'(awvalid); w_n += int'(wvalid); ar_n += int'(arvalid); rr_n += int'(rready);
            if (wvalid && wdata !== wd_exp) wd_ok = 0;
        end
    endtask

    initial begin
        int acc, aw_n, w_n, ar_n, rr_n, rsp_c, g, seen;
        bit wd_ok;
        logic wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [9:0] idx;

        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'h6; ref_mem[0] = 32'h6;
        axis_rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        axis_rst = 0;
        check("reset_outputs",
              64'({cmd_ready, busy, rsp_valid, awvalid, wvalid, arvalid, rready, rsp_err}),
              64'b1000_0000);
        check("reset_rdata", 64'(rsp_rdata), 64'd0);

        // Zero-wait write.
        wait_idle();
        issue(1'b1, 12'h010, 32'd600, 1, acc);
        watch(32'd600, aw_n, w_n, ar_n, rr_n, rsp_c, wd_ok);
        check("wr0_aw_cycles", 64'(aw_n), 64'd1);
        check("wr0_w_cycles", 64'(w_n), 64'd1);
        check("wr0_rsp_latency", 64'(rsp_c - acc), 64'd2);

        // W accepted three cycles after AW.
        w_dly = 3;
        wait_idle();
        issue(1'b1, 12'h020, 32'hFFFF_FFF6, 1, acc);
        watch(32'hFFFF_FFF6, aw_n, w_n, ar_n, rr_n, rsp_c, wd_ok);
        check("wr1_aw_cycles", 64'(aw_n), 64'd1);
        check("wr1_w_cycles", 64'(w_n), 64'd4);
        check("wr1_wdata_stable", 64'(wd_ok), 64'd1);
        check("wr1_rsp_latency", 64'(rsp_c - acc), 64'd5);
        w_dly = 0;

        // Zero-wait read.
        wait_idle();
        issue(1'b0, 12'h010, '0, 1, acc);
        watch('0, aw_n, w_n, ar_n, rr_n, rsp_c, wd_ok);
        check("rd0_rsp_latency", 64'(rsp_c - acc), 64'd3);

        // Read with rvalid two cycles after rready.
        r_dly = 2;
        wait_idle();
        issue(1'b0, 12'h000, '0, 1, acc);
        watch('0, aw_n, w_n, ar_n, rr_n, rsp_c, wd_ok);
        check("rd1_ar_cycles", 64'(ar_n), 64'd1);
        check("rd1_rready_cycles", 64'(rr_n), 64'd3);
        check("rd1_rsp_latency", 64'(rsp_c - acc), 64'd5);
        r_dly = 0;

        // AR never accepted: timeout after 8 cycles.
        ar_dly = STALL;
        wait_idle();
        issue(1'b0, 12'h024, '0, 1, acc);
        watch('0, aw_n, w_n, ar_n, rr_n, rsp_c, wd_ok);
        check("to_ar_cycles", 64'(ar_n), 64'd8);
        check("to_rready_cycles", 64'(rr_n), 64'd0);
        check("to_rsp_latency", 64'(rsp_c - acc), 64'd9);
        ar_dly = 0;

        // Misaligned write: no bus traffic, immediate error.
        wait_idle();
        issue(1'b1, 12'h022, 32'h1234, 1, acc);
        watch(32'h1234, aw_n, w_n, ar_n, rr_n, rsp_c, wd_ok);
        check("mis_bus_cycles", 64'(aw_n + w_n + ar_n), 64'd0);
        check("mis_rsp_latency", 64'(rsp_c - acc), 64'd1);

        // Reset during RD_D drops the command silently.
        r_dly = STALL;
        wait_idle();
        issue(1'b0, 12'h030, '0, 0, acc);
        g = 0;
        while (!rready && g < 20) begin @(negedge axis_clk); g++; end
        check("rst_reached_rd_d", 64'(rready), 64'd1);
        axis_rst = 1;
        @(posedge axis_clk);
        #1;
        check("rst_mid_outputs",
              64'({cmd_ready, busy, rsp_valid, awvalid, wvalid, arvalid, rready, rsp_err}),
              64'b1000_0000);
        check("rst_mid_rdata", 64'(rsp_rdata), 64'd0);
        @(negedge axis_clk);
        axis_rst = 0;
        rsp_mode = 2;
        r_dly = 0;
        seen = 0;
        repeat (6) begin @(negedge axis_clk); seen += int'(rsp_valid); end
        check("rst_no_rsp", 64'(seen), 64'd0);
        rsp_mode = 1;
        issue(1'b0, 12'h020, '0, 1, acc);
        watch('0, aw_n, w_n, ar_n, rr_n, rsp_c, wd_ok);
        check("post_rst_rsp_latency", 64'(rsp_c - acc), 64'd3);

        // Randomized traffic.
        rsp_mode = 0;
        for (int n = 0; n < 160; n++) begin
            wait_idle();
            wr = 1'($urandom_range(0, 1));
            idx = 10'($urandom_range(0, 1023));
            a = {idx, 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d = $urandom;
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: aw_dly = STALL;
                    1: w_dly = STALL;
                    2: ar_dly = STALL;
                    default: r_dly = STALL;
                endcase
            end
            issue(wr, a, d, 1, acc);
        end

        g = 0;
        while (exp_q.size() != 0 && g < 500) begin @(negedge axis_clk); g++; end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge axis_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
